frame_host_link: RTL and testbench
==================================

// Module: frame_host_link
// PURPOSE
//  Peer endpoint of the secure-module serial frame link: the host/PC side as an RTL
//  initiator (test harness or bridge FPGA). Sends byte-stuffed frames to the device and
//  waits for its confirmation byte. Accepts device frames and answers OKAY/ERROR.
//  Sits between a frame source/sink and an RS232 byte transmitter/receiver pair.
// PARAMETERS
//  FRAME_SIZE   16     payload bytes per frame (excluding START/END/escape bytes)
//  ACK_TIMEOUT  100000 clk cycles to wait for a confirmation byte before timing out
//  MAX_RETRY    3      retransmissions after ERROR/timeout (used only with RETRY_EN)
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              async reset, active low
//  send_frame     in   FRAME_SIZE*8   frame to send; byte 0 = bits [0:7]
//  send_valid     in   1              request to send send_frame
//  send_ready     out  1              high in IDLE only; transfer when valid&&ready
//  send_done      out  1              1-cycle pulse when send transaction ends
//  send_status    out  2              0 OK, 1 ERROR, 2 FATAL, 3 TIMEOUT; valid with send_done
//  rx_frame       out  FRAME_SIZE*8   last good received frame; held until next good frame
//  rx_frame_valid out  1              1-cycle pulse when rx_frame is updated
//  tx_data        out  8              byte presented to UART transmitter
//  tx_req         out  1              level: tx_data is valid (UART DRL)
//  tx_load        in   1              UART pulse: tx_data consumed
//  rx_data        in   8              byte from UART receiver
//  rx_store       in   1              1-cycle pulse: rx_data valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, rx_frame all-zero.
//  Constants: START 0x06, END 0x07, ESC 0x14, XOR 0x20, OKAY 0x05, ERROR 0x04, FATAL 0x08.
//  Byte handshake: tx_data stable while tx_req=1; on tx_load, next byte is presented the
//   following cycle, or tx_req drops after the last byte.
//  States: IDLE, TX_FRAME, WAIT_ACK, RX_FRAME, TX_REPLY.
//  IDLE: on rx_store with 0x06 -> RX_FRAME (takes priority over send_valid in the same
//   cycle; send_ready=0 from the next cycle). rx_data 0x08 in IDLE is ignored.
//   On send_valid&&send_ready: latch frame, retry=0 -> TX_FRAME.
//  TX_FRAME: emit 0x06, FRAME_SIZE bytes in index order, then 0x07. A byte in
//   {0x06,0x07,0x14} goes out as 0x14 then byte^0x20. After 0x07 is loaded -> WAIT_ACK
//   and the timeout counter clears.
//  WAIT_ACK: rx 0x05 -> done OK; 0x04 -> ERROR; 0x08 -> done FATAL, IDLE;
//   any other byte is ignored. Timer reaching ACK_TIMEOUT -> TIMEOUT.
//   ERROR/TIMEOUT end the transaction (see RETRY_EN). send_done fires the cycle IDLE is re-entered.
//  RX_FRAME: 0x14 sets the escape flag and the next byte is stored ^0x20. A non-flag byte is
//   stored at index cnt and cnt increments. On unescaped 0x07: if cnt==FRAME_SIZE, rx_frame is
//   updated with rx_frame_valid and the reply is OKAY; otherwise the frame is discarded and the
//   reply is ERROR. A store that would make cnt>FRAME_SIZE sets reply ERROR and the state goes
//   to TX_REPLY immediately. An unescaped 0x06 restarts with cnt=0.
//  TX_REPLY: send one reply byte, then go to IDLE on tx_load.
//  Only one RX_FRAME transaction runs at a time; bytes during TX_FRAME are dropped.
//  rst_n low mid-frame: all activity aborts immediately, tx_req=0, no done pulse.
// CONFIGURATION
//  RETRY_EN defined: on ERROR/TIMEOUT with retry<MAX_RETRY, retry++ and the same latched
//   frame is resent (TX_FRAME). send_done fires only at final OK/FATAL, or when retries are
//   exhausted (status is the last failure).
//  RETRY_EN undefined: ERROR/TIMEOUT end the transaction at once; retry counter absent.
// STRUCTURE
//  Package frame_link_pkg: the byte constants above, send_status codes, state encoding.
//  Sub-module frame_destuffer: rx escape flag, byte index, frame register, END/overflow
//   detection; the top holds the FSM, stuffer, timeout and retry logic.
// TESTING
//  1 send bytes 00 01..0F -> tx 06 00 01..0F 07; rx 05 -> send_done, status 0.
//  2 payload byte 3 = 0x07, byte 5 = 0x14 -> tx has 14 27 and 14 34; total 21 bytes.
//  3 rx 06, 16 bytes incl. 14 26, 07 -> rx_frame_valid, byte=0x06, tx 05.
//  4 rx 06, 10 bytes, 07 -> no rx_frame_valid, tx 04; rx_frame unchanged.
//  5 send, no reply for ACK_TIMEOUT -> status 3 (RETRY_EN: 3 resends, then status 3).
//  6 send, rx 04 then (retry) 08 -> status 2; rst_n low mid-TX_FRAME -> tx_req=0 next edge.

Source files
------------

// File: rtl/frame_link_pkg.sv
// Shared constants, status codes and FSM encoding for the host side of the serial frame link.
package frame_link_pkg;

  localparam logic [7:0] START_BYTE = 8'h06;
  localparam logic [7:0] END_BYTE   = 8'h07;
  localparam logic [7:0] ESC_BYTE   = 8'h14;
  localparam logic [7:0] ESC_XOR    = 8'h20;
  localparam logic [7:0] OKAY_BYTE  = 8'h05;
  localparam logic [7:0] ERROR_BYTE = 8'h04;
  localparam logic [7:0] FATAL_BYTE = 8'h08;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ERROR   = 2'd1,
    ST_FATAL   = 2'd2,
    ST_TIMEOUT = 2'd3
  } send_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_FRAME,
    S_WAIT_ACK,
    S_RX_FRAME,
    S_TX_REPLY
  } state_e;

  function automatic logic needs_escape(input logic [7:0] b);
    return (b == START_BYTE) || (b == END_BYTE) || (b == ESC_BYTE);
  endfunction

endpackage

// File: rtl/frame_destuffer.sv
// Receive-side frame decoder: un-escapes incoming bytes, collects the payload and
// reports END/overflow together with whether the reply should be OKAY.
module frame_destuffer
  import frame_link_pkg::*;
#(
  parameter int FRAME_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_i,
  output logic                    done_o,
  output logic                    reply_ok_o,
  output logic [FRAME_SIZE*8-1:0] frame_o,
  output logic                    frame_valid_o
);

  localparam int CW = $clog2(FRAME_SIZE + 1);

  logic                    esc_q, esc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FRAME_SIZE*8-1:0] acc_q, acc_d;
  logic [FRAME_SIZE*8-1:0] frame_q, frame_d;
  logic                    frame_valid_q, frame_valid_d;
  logic [7:0]              data_byte;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    esc_d         = esc_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    done_o        = 1'b0;
    reply_ok_o    = 1'b0;
    data_byte     = esc_q ? (byte_i ^ ESC_XOR) : byte_i;

    if (clear_i) begin
      esc_d = 1'b0;
      cnt_d = '0;
    end else if (byte_valid_i) begin
      if (!esc_q && byte_i == ESC_BYTE) begin
        esc_d = 1'b1;
      end else if (!esc_q && byte_i == START_BYTE) begin
        cnt_d = '0;
      end else if (!esc_q && byte_i == END_BYTE) begin
        done_o = 1'b1;
        cnt_d  = '0;
        if (cnt_q == CW'(FRAME_SIZE)) begin
          reply_ok_o    = 1'b1;
          frame_d       = acc_q;
          frame_valid_d = 1'b1;
        end
      end else begin
        esc_d = 1'b0;
        // A data byte beyond the payload length aborts the frame right away.
        if (cnt_q == CW'(FRAME_SIZE)) begin
          done_o = 1'b1;
          cnt_d  = '0;
        end else begin
          acc_d[8*cnt_q +: 8] = data_byte;
          cnt_d               = cnt_q + CW'(1);
        end
      end
    end
  end

  // NOTE: the payload registers are plain flops and rx_frame must read zero after reset,
  // so they are reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esc_q         <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      esc_q         <= esc_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;

endmodule

// File: rtl/frame_host_link.sv
// Host-side initiator of the serial frame link: stuffs and sends frames, waits for the
// device confirmation, and answers device frames. Optional RETRY_EN macro enables resends.
module frame_host_link
  import frame_link_pkg::*;
#(
  parameter int FRAME_SIZE  = 16,
  parameter int ACK_TIMEOUT = 100000
`ifdef RETRY_EN
  ,
  parameter int MAX_RETRY   = 3
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FRAME_SIZE*8-1:0] send_frame,
  input  logic                    send_valid,
  output logic                    send_ready,
  output logic                    send_done,
  output logic [1:0]              send_status,
  output logic [FRAME_SIZE*8-1:0] rx_frame,
  output logic                    rx_frame_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_req,
  input  logic                    tx_load,
  input  logic [7:0]              rx_data,
  input  logic                    rx_store
);

  localparam int IW = $clog2(FRAME_SIZE + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [FRAME_SIZE*8-1:0] frame_q, frame_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    tx_esc_q, tx_esc_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_req_q, tx_req_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    send_ready_q, send_ready_d;
  logic                    send_done_q, send_done_d;
  logic [1:0]              send_status_q, send_status_d;
`ifdef RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0]           retry_q, retry_d;
`endif

  logic         rx_clear, rx_byte_valid, rx_done, rx_ok;
  logic         ack_fail;
  send_status_e fail_status;
  logic [7:0]   cur_byte;

  assign rx_byte_valid = (state_q == S_RX_FRAME) && rx_store;

  frame_destuffer #(.FRAME_SIZE(FRAME_SIZE)) u_destuffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (rx_clear),
    .byte_valid_i (rx_byte_valid),
    .byte_i       (rx_data),
    .done_o       (rx_done),
    .reply_ok_o   (rx_ok),
    .frame_o      (rx_frame),
    .frame_valid_o(rx_frame_valid)
  );

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    idx_d         = idx_q;
    tx_esc_d      = tx_esc_q;
    tx_data_d     = tx_data_q;
    tx_req_d      = tx_req_q;
    timer_d       = timer_q;
    send_done_d   = 1'b0;
    send_status_d = send_status_q;
    rx_clear      = 1'b0;
    ack_fail      = 1'b0;
    fail_status   = ST_ERROR;
    cur_byte      = (idx_q < IW'(FRAME_SIZE)) ? frame_q[8*idx_q +: 8] : 8'h00;
`ifdef RETRY_EN
    retry_d       = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_store && rx_data == START_BYTE) begin
          state_d  = S_RX_FRAME;
          rx_clear = 1'b1;
        end else if (send_valid && send_ready_q) begin
          frame_d   = send_frame;
          state_d   = S_TX_FRAME;
          tx_req_d  = 1'b1;
          tx_data_d = START_BYTE;
          idx_d     = '0;
          tx_esc_d  = 1'b0;
`ifdef RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      S_TX_FRAME: begin
        // tx_data_q only equals END after the whole payload; escaped bytes never produce it.
        if (tx_load) begin
          if (tx_data_q == END_BYTE) begin
            state_d  = S_WAIT_ACK;
            tx_req_d = 1'b0;
            timer_d  = '0;
          end else if (tx_esc_q) begin
            tx_data_d = cur_byte ^ ESC_XOR;
            tx_esc_d  = 1'b0;
            idx_d     = idx_q + IW'(1);
          end else if (idx_q == IW'(FRAME_SIZE)) begin
            tx_data_d = END_BYTE;
          end else if (needs_escape(cur_byte)) begin
            tx_data_d = ESC_BYTE;
            tx_esc_d  = 1'b1;
          end else begin
            tx_data_d = cur_byte;
            idx_d     = idx_q + IW'(1);
          end
        end
      end
      S_WAIT_ACK: begin
        if (rx_store && rx_data == OKAY_BYTE) begin
          state_d       = S_IDLE;
          send_done_d   = 1'b1;
          send_status_d = ST_OK;
        end else if (rx_store && rx_data == FATAL_BYTE) begin
          state_d       = S_IDLE;
          send_done_d   = 1'b1;
          send_status_d = ST_FATAL;
        end else if (rx_store && rx_data == ERROR_BYTE) begin
          ack_fail    = 1'b1;
          fail_status = ST_ERROR;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_fail    = 1'b1;
          fail_status = ST_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RX_FRAME: begin
        if (rx_done) begin
          state_d   = S_TX_REPLY;
          tx_req_d  = 1'b1;
          tx_data_d = rx_ok ? OKAY_BYTE : ERROR_BYTE;
        end
      end
      S_TX_REPLY: begin
        if (tx_load) begin
          state_d  = S_IDLE;
          tx_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ack_fail) begin
`ifdef RETRY_EN
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d   = retry_q + RW'(1);
        state_d   = S_TX_FRAME;
        tx_req_d  = 1'b1;
        tx_data_d = START_BYTE;
        idx_d     = '0;
        tx_esc_d  = 1'b0;
      end else begin
        state_d       = S_IDLE;
        send_done_d   = 1'b1;
        send_status_d = fail_status;
      end
`else
      state_d       = S_IDLE;
      send_done_d   = 1'b1;
      send_status_d = fail_status;
`endif
    end

    send_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      frame_q       <= '0;
      idx_q         <= '0;
      tx_esc_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_req_q      <= 1'b0;
      timer_q       <= '0;
      send_ready_q  <= 1'b0;
      send_done_q   <= 1'b0;
      send_status_q <= 2'd0;
`ifdef RETRY_EN
      retry_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      idx_q         <= idx_d;
      tx_esc_q      <= tx_esc_d;
      tx_data_q     <= tx_data_d;
      tx_req_q      <= tx_req_d;
      timer_q       <= timer_d;
      send_ready_q  <= send_ready_d;
      send_done_q   <= send_done_d;
      send_status_q <= send_status_d;
`ifdef RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign send_ready  = send_ready_q;
  assign send_done   = send_done_q;
  assign send_status = send_status_q;
  assign tx_data     = tx_data_q;
  assign tx_req      = tx_req_q;

endmodule

// File: tb/tb_frame_host_link.sv
// Self-checking bench for frame_host_link: the bench plays UART and device, models the
// link at frame level, and compares every transaction plus per-cycle tx handshake rules.
module tb_frame_host_link;

  localparam int FS = 16;
  localparam int FW = FS * 8;
  localparam int TO = 200;
  localparam int MR = 3;
`ifdef RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef logic [FW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          rst_n;
  frame_t        send_frame;
  logic          send_valid, send_ready, send_done;
  logic [1:0]    send_status;
  frame_t        rx_frame;
  logic          rx_frame_valid;
  logic [7:0]    tx_data;
  logic          tx_req, tx_load;
  logic [7:0]    rx_data;
  logic          rx_store;

  frame_host_link #(.FRAME_SIZE(FS), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .send_frame(send_frame), .send_valid(send_valid), .send_ready(send_ready),
    .send_done(send_done), .send_status(send_status),
    .rx_frame(rx_frame), .rx_frame_valid(rx_frame_valid),
    .tx_data(tx_data), .tx_req(tx_req), .tx_load(tx_load),
    .rx_data(rx_data), .rx_store(rx_store)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_load_cyc = 0;
  int         uart_gap = 0;
  bit         uart_en = 1'b0;
  bq_t        tx_q;
  logic [1:0] done_q[$];
  int         done_cyc_q[$];
  frame_t     rxv_q[$];
  frame_t     model_rx;
  logic       prev_req = 1'b0;
  logic       prev_load = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle observer: tx handshake stability and capture of every output event.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (prev_req && tx_req && !prev_load) check("tx_data_stable", tx_data, prev_data);
      if (tx_req && tx_load) begin
        tx_q.push_back(tx_data);
        last_load_cyc = cyc;
      end
      if (send_done) begin
        done_q.push_back(send_status);
        done_cyc_q.push_back(cyc);
      end
      if (rx_frame_valid) rxv_q.push_back(rx_frame);
      prev_req  = tx_req;
      prev_data = tx_data;
      prev_load = tx_load;
    end
  end

  // UART transmitter: consumes each presented byte after a random delay.
  always @(posedge clk) begin
    #2;
    if (!rst_n || !uart_en) begin
      tx_load = 1'b0;
    end else if (tx_load) begin
      tx_load  = 1'b0;
      uart_gap = $urandom_range(0, 2);
    end else if (tx_req) begin
      if (uart_gap == 0) tx_load = 1'b1;
      else uart_gap--;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- frame-level model ----------------
  function automatic bq_t encode(input bq_t p, input bit add_end);
    bq_t q;
    logic [7:0] b;
    q.push_back(8'h06);
    for (int i = 0; i < p.size(); i++) begin
      b = p[i];
      if (b == 8'h06 || b == 8'h07 || b == 8'h14) begin
        q.push_back(8'h14);
        q.push_back(b ^ 8'h20);
      end else begin
        q.push_back(b);
      end
    end
    if (add_end) q.push_back(8'h07);
    return q;
  endfunction

  function automatic frame_t pack(input bq_t p);
    frame_t f = '0;
    for (int i = 0; i < FS && i < p.size(); i++) f[8*i +: 8] = p[i];
    return f;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] specials [3];
    specials[0] = 8'h06; specials[1] = 8'h07; specials[2] = 8'h14;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 2)];
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_store = 1'b1;
    step();
    rx_store = 1'b0;
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!send_ready && t < 2000) begin
      step();
      t++;
    end
    if (!send_ready) check("ready_timeout", send_ready, 1);
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_q.size() < n && t < 3000) begin
      step();
      t++;
    end
  endtask

  task automatic take_seq(input string name, input bq_t exp, output bq_t got);
    int  first = 0;
    bit  found = 1'b0;
    got  = tx_q;
    tx_q = {};
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      if (!found && got[i] !== exp[i]) begin
        first = i;
        found = 1'b1;
      end
    end
    if (got.size() > 0 && exp.size() > 0) check(name, got[first], exp[first]);
  endtask

  task automatic do_send(input bq_t p, input bq_t script, output bq_t last_tx);
    bq_t        exp_tx;
    logic [1:0] exp_st = 2'd0;
    int         n_att = 0;
    int         max_att;
    bit         stop = 1'b0;
    int         t = 0;
    exp_tx  = encode(p, 1'b1);
    max_att = RETRY ? MR + 1 : 1;
    for (int i = 0; i < script.size() && !stop; i++) begin
      n_att++;
      case (script[i])
        8'h05:   begin exp_st = 2'd0; stop = 1'b1; end
        8'h08:   begin exp_st = 2'd2; stop = 1'b1; end
        8'h04:   exp_st = 2'd1;
        default: exp_st = 2'd3;
      endcase
      if (n_att == max_att) stop = 1'b1;
    end

    wait_ready();
    send_frame = pack(p);
    send_valid = 1'b1;
    step();
    send_valid = 1'b0;
    for (int a = 0; a < n_att; a++) begin
      wait_tx(exp_tx.size());
      take_seq("tx_frame", exp_tx, last_tx);
      if ($urandom_range(0, 3) == 0) rx_byte(8'($urandom_range(9, 255)));
      if (script[a] != 8'hFF) rx_byte(script[a]);
    end
    while (done_q.size() == 0 && t < TO + 100) begin
      step();
      t++;
    end
    check("send_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("send_status", done_q[0], exp_st);
      if (exp_st == 2'd3) begin
        t = done_cyc_q[0] - last_load_cyc;
        check("timeout_latency", (t >= TO && t <= TO + 2), 1);
      end
    end
    done_q     = {};
    done_cyc_q = {};
    check("no_extra_tx", tx_q.size(), 0);
  endtask

  task automatic do_rx(input bq_t prefix, input bq_t p, input bit with_end);
    bq_t        stream;
    bq_t        got;
    bit         exp_valid;
    logic [7:0] exp_reply [$];
    exp_valid = (p.size() == FS) && with_end;
    exp_reply = {exp_valid ? 8'h05 : 8'h04};
    stream    = prefix;
    stream    = {stream, encode(p, with_end)};
    wait_ready();
    foreach (stream[i]) rx_byte(stream[i]);
    wait_tx(1);
    take_seq("rx_reply", exp_reply, got);
    wait_ready();
    check("rx_valid_count", rxv_q.size(), exp_valid);
    if (exp_valid) begin
      model_rx = pack(p);
      if (rxv_q.size() > 0) check("rx_valid_frame", rxv_q[0], model_rx);
    end
    rxv_q = {};
    check("rx_frame_held", rx_frame, model_rx);
    check("rx_no_send_done", done_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bq_t p, s, got, pre;
    int  t;
    rst_n      = 1'b0;
    send_frame = '0;
    send_valid = 1'b0;
    tx_load    = 1'b0;
    rx_data    = 8'h00;
    rx_store   = 1'b0;
    model_rx   = '0;
    uart_en    = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_tx_req", tx_req, 0);
    check("rst_send_ready", send_ready, 0);
    check("rst_send_done", send_done, 0);
    check("rst_send_status", send_status, 0);
    check("rst_rx_valid", rx_frame_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_frame", rx_frame, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Plain frame 00..0F, OKAY.
    p = {};
    for (int i = 0; i < FS; i++) p.push_back(8'(i));
    s = {8'h05};
    do_send(p, s, got);
    check("s1_len", got.size(), 20);
    check("s1_esc_06_07", {got[7], got[8], got[9], got[10]}, 32'h1426_1427);
    check("s1_last", got[19], 8'h07);

    // Escapes at bytes 3 and 5 (plus one at byte 10): 21 bytes on the wire.
    p = {};
    for (int i = 0; i < FS; i++) p.push_back(8'(8'h40 + i));
    p[3] = 8'h07; p[5] = 8'h14; p[10] = 8'h06;
    do_send(p, s, got);
    check("s2_len", got.size(), 21);
    check("s2_esc3", {got[4], got[5]}, 16'h1427);
    check("s2_esc5", {got[7], got[8]}, 16'h1434);

    // Good device frame containing an escaped 0x06.
    p = {};
    for (int i = 0; i < FS; i++) p.push_back(8'(8'h50 + i));
    p[4] = 8'h06;
    pre = {};
    do_rx(pre, p, 1'b1);
    check("s3_byte4", rx_frame[39:32], 8'h06);

    // Short device frame: ERROR reply, rx_frame untouched.
    p = {};
    for (int i = 0; i < 10; i++) p.push_back(8'(8'hA0 + i));
    do_rx(pre, p, 1'b1);

    // Overflow: 17 data bytes without END.
    p = {};
    for (int i = 0; i < FS + 1; i++) p.push_back(rand_byte());
    do_rx(pre, p, 1'b0);

    // Restart on a second START inside the frame.
    p = {};
    for (int i = 0; i < FS; i++) p.push_back(rand_byte());
    pre = {8'h06, 8'h11, 8'h22, 8'h33};
    do_rx(pre, p, 1'b1);
    pre = {};

    // No reply at all: timeout (with resends when retries are built in).
    p = {};
    for (int i = 0; i < FS; i++) p.push_back(rand_byte());
    s = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    do_send(p, s, got);

    // ERROR then FATAL.
    s = {8'h04, 8'h08, 8'h05};
    do_send(p, s, got);

    // FATAL byte while idle is ignored.
    wait_ready();
    rx_byte(8'h08);
    repeat (5) step();
    check("idle_fatal_no_tx", tx_q.size(), 0);
    check("idle_fatal_ready", send_ready, 1);

    // Randomised mix of sends and receptions.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        p = {};
        for (int i = 0; i < FS; i++) p.push_back(rand_byte());
        s = {};
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          t = $urandom_range(0, 9);
          s.push_back(t == 0 ? 8'hFF : t < 3 ? 8'h04 : t == 3 ? 8'h08 : 8'h05);
        end
        s.push_back(8'h05);
        do_send(p, s, got);
      end else begin
        t = $urandom_range(0, 3);
        p = {};
        for (int i = 0; i < (t == 0 ? FS - 3 : t == 3 ? FS + 1 : FS); i++) p.push_back(rand_byte());
        do_rx(pre, p, t != 3);
      end
    end

    // Reset in the middle of a frame transmission.
    wait_ready();
    send_frame = '1;
    send_valid = 1'b1;
    step();
    send_valid = 1'b0;
    t = 0;
    while (tx_q.size() < 4 && t < 500) begin
      step();
      t++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_req", tx_req, 0);
    check("midrst_send_done", send_done, 0);
    check("midrst_ready", send_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("midrst_no_done", done_q.size(), 0);
    check("midrst_rx_frame", rx_frame, 0);
    tx_q     = {};
    model_rx = '0;

    p = {};
    for (int i = 0; i < FS; i++) p.push_back(rand_byte());
    s = {8'h05};
    do_send(p, s, got);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
